lab1_response_checker: RTL and testbench

- Response-side counterpart to the exhaustive stimulus sweep used on the 2-bit lab1 function units (inputs a0,a1,b0,b1,i0,i1; outputs f0,f1).
- Accepts one 6-bit vector per handshake and holds it on `dut_vec` for the DUT and reference model.
- After a settle delay, compares the DUT response against the reference response, counts mismatches and captures the first failure.
- Reports done/pass after a full sweep, so hardware self-checks without `$display` inspection.

---
 rtl/lab1_chk_pkg.sv | 27 ++
 rtl/lab1_response_checker_if.sv | 12 +
 rtl/lab1_settle_timer.sv | 27 ++
 rtl/lab1_response_checker.sv | 147 ++++++++++++++
 tb/tb_lab1_response_checker.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab1_chk_pkg.sv
// Shared types and constants for the lab1 response checker.
// Holds the FSM state encoding, vector/response widths and a popcount helper.
package lab1_chk_pkg;

  localparam int VEC_W           = 6;
  localparam int F_W             = 2;
  localparam int NUM_ALL_VECTORS = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  // Used to report how many distinct vectors have been compared.
  function automatic logic [6:0] popcount64(input logic [NUM_ALL_VECTORS-1:0] bits);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < NUM_ALL_VECTORS; i++) begin
      n = n + 7'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lab1_response_checker_if.sv
// Vector handshake between a stimulus producer (master) and the checker (slave).
interface lab1_response_checker_if;
  import lab1_chk_pkg::*;

  logic             vec_valid;
  logic [VEC_W-1:0] vec;
  logic             vec_ready;

  modport master (output vec_valid, output vec, input vec_ready);
  modport slave  (input vec_valid, input vec, output vec_ready);

endinterface

// File: rtl/lab1_settle_timer.sv
// Loadable down-counter that stops at zero; gives the DUT time to settle
// between applying a vector and sampling its response.
module lab1_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lab1_response_checker.sv
// Compares DUT and reference responses over a vector sweep, counting mismatches
// and recording the first one. Optional macro LAB1_CHK_COVERAGE_EN ends the sweep on full vector coverage.
module lab1_response_checker
  import lab1_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 5,
  parameter int NUM_VECTORS   = 64,
  parameter int CNT_W         = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  lab1_response_checker_if.slave  bus,
  output logic [VEC_W-1:0]        dut_vec,
  input  logic [F_W-1:0]          ref_f,
  input  logic [F_W-1:0]          dut_f,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        err_count,
  output logic                    first_err_valid,
  output logic [VEC_W-1:0]        first_err_vec,
  output logic [F_W-1:0]          first_err_got,
  output logic [F_W-1:0]          first_err_exp
`ifdef LAB1_CHK_COVERAGE_EN
  ,
  output logic [6:0]              cov_count
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       accept;
  logic       mismatch;
  logic       start_ok;
  logic       last_sample;
  logic       settle_zero;
  logic [3:0] settle_cnt_unused;

`ifdef LAB1_CHK_COVERAGE_EN
  logic [NUM_ALL_VECTORS-1:0] covered;
  logic [NUM_ALL_VECTORS-1:0] covered_next;

  assign covered_next = covered | (NUM_ALL_VECTORS'(1) << dut_vec);
  assign last_sample  = &covered_next;
  assign cov_count    = popcount64(covered);
`else
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(NUM_VECTORS - 1);
  logic [CNT_W-1:0] sample_cnt;

  assign last_sample = (sample_cnt == LAST_SAMPLE);
`endif

  assign bus.vec_ready = (state == ARMED);
  assign accept        = (state == ARMED) && bus.vec_valid;
  assign mismatch      = (dut_f != ref_f);
  assign start_ok      = start && ((state == IDLE) || (state == DONE));
  assign busy          = (state == ARMED) || (state == SETTLE) || (state == COMPARE);

  lab1_settle_timer #(.W(4)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (state == SETTLE),
    .load_val (SETTLE_LOAD),
    .count    (settle_cnt_unused),
    .zero     (settle_zero)
  );

  // A start from IDLE or DONE wipes every result before arming a new sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      dut_vec         <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
`ifdef LAB1_CHK_COVERAGE_EN
      covered         <= '0;
`else
      sample_cnt      <= '0;
`endif
    end else if (start_ok) begin
      state           <= ARMED;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
`ifdef LAB1_CHK_COVERAGE_EN
      covered         <= '0;
`else
      sample_cnt      <= '0;
`endif
    end else begin
      case (state)
        ARMED: begin
          if (bus.vec_valid) begin
            dut_vec <= bus.vec;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_zero) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= dut_vec;
              first_err_got   <= dut_f;
              first_err_exp   <= ref_f;
            end
          end
`ifdef LAB1_CHK_COVERAGE_EN
          covered <= covered_next;
`else
          sample_cnt <= sample_cnt + CNT_W'(1);
`endif
          if (last_sample) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            state <= ARMED;
          end
        end
        IDLE, DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_response_checker.sv
// Scoreboard bench for lab1_response_checker: expected per-sample results are
// queued at drive time and checked when the checker finishes each compare.
module tb_lab1_response_checker;
  import lab1_chk_pkg::*;

  localparam int SETTLE_CYCLES = 5;
  localparam int NUM_VECTORS   = 64;
  localparam int CNT_W         = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [VEC_W-1:0] dut_vec;
  logic [F_W-1:0]   ref_f;
  logic [F_W-1:0]   dut_f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             first_err_valid;
  logic [VEC_W-1:0] first_err_vec;
  logic [F_W-1:0]   first_err_got;
  logic [F_W-1:0]   first_err_exp;
`ifdef LAB1_CHK_COVERAGE_EN
  logic [6:0]       cov_count;
`endif

  logic [F_W-1:0] fault_mask;
  logic           override_en;

  lab1_response_checker_if bus ();

  lab1_response_checker #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .NUM_VECTORS   (NUM_VECTORS),
    .CNT_W         (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .bus             (bus),
    .dut_vec         (dut_vec),
    .ref_f           (ref_f),
    .dut_f           (dut_f),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .first_err_got   (first_err_got),
    .first_err_exp   (first_err_exp)
`ifdef LAB1_CHK_COVERAGE_EN
    ,
    .cov_count       (cov_count)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the lab1 function unit: any fixed function of the vector will do.
  function automatic logic [1:0] ref_fn(input logic [5:0] v);
    return v[1:0] ^ v[3:2] ^ v[5:4];
  endfunction

  assign ref_f = override_en ? ~ref_fn(dut_vec) : ref_fn(dut_vec);
  assign dut_f = ref_fn(dut_vec) ^ fault_mask;

  typedef struct {
    logic [CNT_W-1:0] err;
    logic             done;
    logic             pass;
  } exp_t;

  exp_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  int          m_err;
  int          m_samples;
  logic [63:0] m_cov;
  logic        m_done;
  logic        m_first_valid;
  logic [5:0]  m_first_vec;
  logic [1:0]  m_first_got;
  logic [1:0]  m_first_exp;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelStart();
    m_err         = 0;
    m_samples     = 0;
    m_cov         = '0;
    m_done        = 1'b0;
    m_first_valid = 1'b0;
    m_first_vec   = '0;
    m_first_got   = '0;
    m_first_exp   = '0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // chg > 0 flips ref_f that many clocks after the accepting edge.
  task automatic applyStimulus(input logic [5:0] v, input logic [1:0] fmask, input int chg);
    exp_t e;
    bit   mism;
    bit   fin;
    int   n;
    int   k;
    mism = (fmask != 2'b00) || ((chg >= 1) && (chg <= SETTLE_CYCLES));
    m_samples++;
    m_cov[v] = 1'b1;
    if (mism) begin
      if (m_err < (1 << CNT_W) - 1) m_err++;
      if (!m_first_valid) begin
        m_first_valid = 1'b1;
        m_first_vec   = v;
        m_first_got   = ref_fn(v) ^ fmask;
        m_first_exp   = (chg != 0) ? ~ref_fn(v) : ref_fn(v);
      end
    end
`ifdef LAB1_CHK_COVERAGE_EN
    m_done = &m_cov;
`else
    m_done = (m_samples == NUM_VECTORS);
`endif
    e.err  = CNT_W'(m_err);
    e.done = m_done;
    e.pass = (m_err == 0);
    sb.push_back(e);

    @(negedge clk);
    override_en   = 1'b0;
    fault_mask    = fmask;
    bus.vec       = v;
    bus.vec_valid = 1'b1;
    n = 0;
    while (!bus.vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.vec_ready) begin
      checkOutput("ready_timeout", 64'(bus.vec_ready), 64'd1);
      bus.vec_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    #1 bus.vec_valid = 1'b0;
    checkOutput("dut_vec_capture", 64'(dut_vec), 64'(v));

    k   = 0;
    fin = 1'b0;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(posedge clk);
      k++;
      if (k == chg) #1 override_en = 1'b1;
      @(negedge clk);
      if (bus.vec_ready || done) fin = 1'b1;
    end
    checkOutput("compare_latency", 64'(k), 64'(SETTLE_CYCLES + 1));

    e = sb.pop_front();
    checkOutput("err_count", 64'(err_count), 64'(e.err));
    checkOutput("done", 64'(done), 64'(e.done));
    if (e.done) checkOutput("pass", 64'(pass), 64'(e.pass));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    start         = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec       = '0;
    fault_mask    = '0;
    override_en   = 1'b0;
    modelStart();

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_pass", 64'(pass), 64'd0);
    checkOutput("reset_err_count", 64'(err_count), 64'd0);
    checkOutput("reset_first_valid", 64'(first_err_valid), 64'd0);
    checkOutput("reset_dut_vec", 64'(dut_vec), 64'd0);
    checkOutput("reset_vec_ready", 64'(bus.vec_ready), 64'd0);
    rst = 1'b0;

    // vec_valid in IDLE must not be captured
    @(negedge clk);
    bus.vec       = 6'h2A;
    bus.vec_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_no_capture", 64'(dut_vec), 64'd0);
    checkOutput("idle_not_busy", 64'(busy), 64'd0);
    checkOutput("idle_vec_ready", 64'(bus.vec_ready), 64'd0);
    bus.vec_valid = 1'b0;

    $display("[TB] sweep 1: exhaustive match");
    modelStart();
    pulseStart();
    checkOutput("armed_busy", 64'(busy), 64'd1);
    checkOutput("armed_vec_ready", 64'(bus.vec_ready), 64'd1);
    for (int v = 0; v < 64; v++) applyStimulus(6'(v), 2'b00, 0);
    checkOutput("sweep1_first_valid", 64'(first_err_valid), 64'd0);

    // vec_valid in DONE must not be captured
    @(negedge clk);
    bus.vec       = 6'h11;
    bus.vec_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("done_no_capture", 64'(dut_vec), 64'h3F);
    checkOutput("done_held", 64'(done), 64'd1);
    checkOutput("done_not_busy", 64'(busy), 64'd0);
    checkOutput("done_err_count", 64'(err_count), 64'd0);
    bus.vec_valid = 1'b0;

    $display("[TB] sweep 2: injected faults at 0x15 and 0x2A");
    modelStart();
    pulseStart();
    checkOutput("restart_clears_done", 64'(done), 64'd0);
    for (int v = 0; v < 64; v++) begin
      if (v == 30) pulseStart();
      applyStimulus(6'(v), ((v == 6'h15) || (v == 6'h2A)) ? 2'b01 : 2'b00, 0);
    end
    checkOutput("fault_first_valid", 64'(first_err_valid), 64'(m_first_valid));
    checkOutput("fault_first_vec", 64'(first_err_vec), 64'h15);
    checkOutput("fault_first_got", 64'(first_err_got), 64'(m_first_got));
    checkOutput("fault_first_exp", 64'(first_err_exp), 64'(m_first_exp));

    $display("[TB] sweep 3: settle timing, then reset mid-sweep");
    modelStart();
    pulseStart();
    applyStimulus(6'h05, 2'b00, 4);
    applyStimulus(6'h06, 2'b00, 6);
    for (int v = 7; v < 15; v++) applyStimulus(6'(v), 2'b00, 0);
    @(negedge clk);
    bus.vec       = 6'h0F;
    bus.vec_valid = 1'b1;
    n = 0;
    while (!bus.vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pre_reset_ready", 64'(bus.vec_ready), 64'd1);
    @(posedge clk);
    #1 bus.vec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", 64'(busy), 64'd0);
    checkOutput("async_reset_err_count", 64'(err_count), 64'd0);
    checkOutput("async_reset_first_valid", 64'(first_err_valid), 64'd0);
    checkOutput("async_reset_first_vec", 64'(first_err_vec), 64'd0);
    checkOutput("async_reset_dut_vec", 64'(dut_vec), 64'd0);
    checkOutput("async_reset_done", 64'(done), 64'd0);
    checkOutput("async_reset_pass", 64'(pass), 64'd0);
    checkOutput("async_reset_vec_ready", 64'(bus.vec_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] sweep 4: duplicates then full sweep");
    modelStart();
    pulseStart();
    for (int i = 0; i < 66 && !m_done; i++) begin
      applyStimulus((i < 2) ? 6'h00 : 6'(i - 2), 2'b00, 0);
    end
    checkOutput("sweep4_done", 64'(done), 64'd1);
    checkOutput("sweep4_pass", 64'(pass), 64'd1);
`ifdef LAB1_CHK_COVERAGE_EN
    checkOutput("sweep4_last_vec", 64'(dut_vec), 64'h3F);
    checkOutput("sweep4_cov_count", 64'(cov_count), 64'd64);
`else
    checkOutput("sweep4_last_vec", 64'(dut_vec), 64'h3D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
